// File: rtl/cache_tag_array.sv
// N-way cache tag store: per-set tags, per-way valid flops and tree pseudo-LRU.
// Clears itself with a one-set-per-cycle sweep after reset; reads return a replacement victim.
module cache_tag_array #(
   parameter int SET_ADDR_WIDTH = 7,
   parameter int TAG_WIDTH      = 21,
   parameter int NUM_WAYS       = 2,
   parameter int ENABLE_BYPASS  = 1,
   localparam int WAY_W         = $clog2(NUM_WAYS)
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          init_busy,
   input  logic                          rd_en,
   input  logic [SET_ADDR_WIDTH-1:0]     rd_addr,
   output logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tag,
   output logic [NUM_WAYS-1:0]           rd_valid,
   output logic [WAY_W-1:0]              rd_victim,
   input  logic                          wr_en,
   input  logic [SET_ADDR_WIDTH-1:0]     wr_addr,
   input  logic [WAY_W-1:0]              wr_way,
   input  logic [TAG_WIDTH-1:0]          wr_tag,
   input  logic                          wr_valid,
   input  logic                          touch_en,
   input  logic [SET_ADDR_WIDTH-1:0]     touch_addr,
   input  logic [WAY_W-1:0]              touch_way
);

   localparam int SETS   = 1 << SET_ADDR_WIDTH;
   localparam int CNT_W  = SET_ADDR_WIDTH + 1;
   localparam int PLRU_W = NUM_WAYS - 1;
   // heap index wide enough to step one level past the last internal node
   localparam int IDX_W  = WAY_W + 1;
   localparam int EXT_W  = 1 << IDX_W;

   typedef enum logic {SWEEP, READY} state_t;

   state_t                    state, state_next;
   logic [CNT_W-1:0]          sweep_cnt;
   logic [SET_ADDR_WIDTH-1:0] sweep_set;
   logic                      sweeping, ready, rd_go, wr_go, touch_go;

   logic [NUM_WAYS-1:0]       valid_mem [SETS];
   logic [PLRU_W-1:0]         plru_mem  [SETS];
   logic [NUM_WAYS*TAG_WIDTH-1:0] cur_tag;

   logic [NUM_WAYS*TAG_WIDTH-1:0] view_tag_p0;
   logic [NUM_WAYS-1:0]           view_valid_p0;
   logic [PLRU_W-1:0]             view_plru_p0;

   function automatic logic [PLRU_W-1:0] plru_access(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
      logic [EXT_W-1:0] tree;
      logic [IDX_W-1:0] node;
      tree = EXT_W'(bits);
      node = '0;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         tree[node] = ~way[l];
         node = {node[IDX_W-2:0], 1'b0} + IDX_W'(1) + IDX_W'(way[l]);
      end
      return tree[PLRU_W-1:0];
   endfunction

   // lowest invalid way wins; otherwise follow the tree bits down to a leaf
   function automatic logic [WAY_W-1:0] pick_victim(input logic [NUM_WAYS-1:0] valid,
                                                    input logic [PLRU_W-1:0]   bits);
      logic [EXT_W-1:0] tree;
      logic [IDX_W-1:0] node;
      logic [WAY_W-1:0] way;
      tree = EXT_W'(bits);
      node = '0;
      way  = '0;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         way[l] = tree[node];
         node   = {node[IDX_W-2:0], 1'b0} + IDX_W'(1) + IDX_W'(tree[node]);
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid[w]) way = WAY_W'(w);
      return way;
   endfunction

   assign sweep_set = sweep_cnt[SET_ADDR_WIDTH-1:0];
   assign sweeping  = (state == SWEEP) && !rst;
   assign ready     = (state == READY) && !rst;
   assign init_busy = (state == SWEEP);
   assign rd_go     = ready && rd_en;
   assign wr_go     = ready && wr_en;
   assign touch_go  = ready && touch_en && !(wr_en && touch_addr == wr_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SWEEP;
         sweep_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == SWEEP) sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      if (state == SWEEP && sweep_cnt == CNT_W'(SETS - 1)) state_next = READY;
   end

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      logic [TAG_WIDTH-1:0] mem [SETS];
      always_ff @(posedge clk) begin
         if (sweeping) mem[sweep_set] <= '0;
         else if (wr_go && wr_way == WAY_W'(w)) mem[wr_addr] <= wr_tag;
      end
      assign cur_tag[w*TAG_WIDTH +: TAG_WIDTH] = mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (sweeping) begin
         valid_mem[sweep_set] <= '0;
         plru_mem[sweep_set]  <= '0;
      end else begin
         if (wr_go) begin
            valid_mem[wr_addr][wr_way] <= wr_valid;
            plru_mem[wr_addr]          <= plru_access(plru_mem[wr_addr], wr_way);
         end
         if (touch_go) plru_mem[touch_addr] <= plru_access(plru_mem[touch_addr], touch_way);
      end
   end

   // stage p0: set view, optionally merged with this cycle's write/touch
   always_comb begin
      view_tag_p0   = cur_tag;
      view_valid_p0 = valid_mem[rd_addr];
      view_plru_p0  = plru_mem[rd_addr];
      if (ENABLE_BYPASS != 0) begin
         if (wr_go && wr_addr == rd_addr) begin
            for (int w = 0; w < NUM_WAYS; w++)
               if (wr_way == WAY_W'(w)) view_tag_p0[w*TAG_WIDTH +: TAG_WIDTH] = wr_tag;
            view_valid_p0[wr_way] = wr_valid;
            view_plru_p0          = plru_access(plru_mem[rd_addr], wr_way);
         end else if (touch_go && touch_addr == rd_addr) begin
            view_plru_p0 = plru_access(plru_mem[rd_addr], touch_way);
         end
      end
   end

   // stage p1: registered read outputs, held while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_tag    <= '0;
         rd_valid  <= '0;
         rd_victim <= '0;
      end else if (rd_go) begin
         rd_tag    <= view_tag_p0;
         rd_valid  <= view_valid_p0;
         rd_victim <= pick_victim(view_valid_p0, view_plru_p0);
      end
   end

endmodule

// File: tb/tb_cache_tag_array.sv
// Bench for cache_tag_array: 2-way bypass/no-bypass pair on shared stimulus plus a 4-way
// bypass instance, all compared every cycle against a set-level reference model.
module tb_cache_tag_array;

   localparam int SAW  = 7;
   localparam int TW   = 21;
   localparam int SETS = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // group 0 drives both 2-way instances
   logic           rd_en0, wr_en0, wr_valid0, touch_en0;
   logic [SAW-1:0] rd_addr0, wr_addr0, touch_addr0;
   logic [0:0]     wr_way0, touch_way0;
   logic [TW-1:0]  wr_tag0;
   // group 1 drives the 4-way instance
   logic           rd_en1, wr_en1, wr_valid1, touch_en1;
   logic [SAW-1:0] rd_addr1, wr_addr1, touch_addr1;
   logic [1:0]     wr_way1, touch_way1;
   logic [TW-1:0]  wr_tag1;

   logic            busy_a, busy_b, busy_c;
   logic [2*TW-1:0] tag_a, tag_b;
   logic [1:0]      val_a, val_b;
   logic [0:0]      vic_a, vic_b;
   logic [4*TW-1:0] tag_c;
   logic [3:0]      val_c;
   logic [1:0]      vic_c;

   cache_tag_array #(.SET_ADDR_WIDTH(SAW), .TAG_WIDTH(TW), .NUM_WAYS(2), .ENABLE_BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .init_busy(busy_a),
      .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_tag(tag_a), .rd_valid(val_a), .rd_victim(vic_a),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_way(wr_way0), .wr_tag(wr_tag0), .wr_valid(wr_valid0),
      .touch_en(touch_en0), .touch_addr(touch_addr0), .touch_way(touch_way0));

   cache_tag_array #(.SET_ADDR_WIDTH(SAW), .TAG_WIDTH(TW), .NUM_WAYS(2), .ENABLE_BYPASS(0)) u_nobyp (
      .clk(clk), .rst(rst), .init_busy(busy_b),
      .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_tag(tag_b), .rd_valid(val_b), .rd_victim(vic_b),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_way(wr_way0), .wr_tag(wr_tag0), .wr_valid(wr_valid0),
      .touch_en(touch_en0), .touch_addr(touch_addr0), .touch_way(touch_way0));

   cache_tag_array #(.SET_ADDR_WIDTH(SAW), .TAG_WIDTH(TW), .NUM_WAYS(4), .ENABLE_BYPASS(1)) u_four (
      .clk(clk), .rst(rst), .init_busy(busy_c),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_tag(tag_c), .rd_valid(val_c), .rd_victim(vic_c),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_way(wr_way1), .wr_tag(wr_tag1), .wr_valid(wr_valid1),
      .touch_en(touch_en1), .touch_addr(touch_addr1), .touch_way(touch_way1));

   // reference state: [group][set][way]; valid and PLRU kept as integer bit masks
   int m_tag [2][SETS][4];
   int m_vm  [2][SETS];
   int m_lru [2][SETS];
   bit m_busy;
   int m_cnt;
   // expected outputs: [group][0 = state before the edge, 1 = state after the edge]
   int e_tag [2][2][4];
   int e_vm  [2][2];
   int e_vic [2][2];
   int n_cmp, n_bad;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // tree over way range [lo, lo+n): node bit 0 means the lower half is next to replace
   function automatic int lru_access(int bits, int nw, int w);
      int node = 0, lo = 0, n = nw, half;
      while (n > 1) begin
         half = n / 2;
         if (w >= lo + half) begin
            bits &= ~(1 << node);
            node = 2 * node + 2;
            lo += half;
         end else begin
            bits |= (1 << node);
            node = 2 * node + 1;
         end
         n = half;
      end
      return bits;
   endfunction

   function automatic int victim_of(int vm, int bits, int nw);
      int node = 0, lo = 0, n = nw, half;
      for (int w = 0; w < nw; w++)
         if (((vm >> w) & 1) == 0) return w;
      while (n > 1) begin
         half = n / 2;
         if (((bits >> node) & 1) != 0) begin
            node = 2 * node + 2;
            lo += half;
         end else begin
            node = 2 * node + 1;
         end
         n = half;
      end
      return lo;
   endfunction

   function automatic logic [127:0] pack_tags(int g, int f, int nw);
      logic [127:0] v = '0;
      for (int w = 0; w < nw; w++) v[w*TW +: TW] = TW'(e_tag[g][f][w]);
      return v;
   endfunction

   function automatic void model_group(int g, int nw, bit re, int ra, bit we, int wa, int ww,
                                       int wt, bit wv, bit te, int ta, int tw);
      int pre_tag [4];
      int pre_vm, pre_lru;
      for (int w = 0; w < 4; w++) pre_tag[w] = m_tag[g][ra][w];
      pre_vm  = m_vm[g][ra];
      pre_lru = m_lru[g][ra];
      if (we) begin
         m_tag[g][wa][ww] = wt;
         if (wv) m_vm[g][wa] |= (1 << ww);
         else    m_vm[g][wa] &= ~(1 << ww);
         m_lru[g][wa] = lru_access(m_lru[g][wa], nw, ww);
      end
      if (te && !(we && ta == wa)) m_lru[g][ta] = lru_access(m_lru[g][ta], nw, tw);
      if (re) begin
         for (int w = 0; w < 4; w++) begin
            e_tag[g][0][w] = pre_tag[w];
            e_tag[g][1][w] = m_tag[g][ra][w];
         end
         e_vm[g][0]  = pre_vm;
         e_vm[g][1]  = m_vm[g][ra];
         e_vic[g][0] = victim_of(pre_vm, pre_lru, nw);
         e_vic[g][1] = victim_of(m_vm[g][ra], m_lru[g][ra], nw);
      end
   endfunction

   task automatic tick();
      if (rst) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         for (int g = 0; g < 2; g++)
            for (int f = 0; f < 2; f++) begin
               e_vm[g][f]  = 0;
               e_vic[g][f] = 0;
               for (int w = 0; w < 4; w++) e_tag[g][f][w] = 0;
            end
      end else if (m_busy) begin
         for (int g = 0; g < 2; g++) begin
            for (int w = 0; w < 4; w++) m_tag[g][m_cnt][w] = 0;
            m_vm[g][m_cnt]  = 0;
            m_lru[g][m_cnt] = 0;
         end
         m_cnt++;
         if (m_cnt == SETS) m_busy = 1'b0;
      end else begin
         model_group(0, 2, rd_en0, int'(rd_addr0), wr_en0, int'(wr_addr0), int'(wr_way0),
                     int'(wr_tag0), wr_valid0, touch_en0, int'(touch_addr0), int'(touch_way0));
         model_group(1, 4, rd_en1, int'(rd_addr1), wr_en1, int'(wr_addr1), int'(wr_way1),
                     int'(wr_tag1), wr_valid1, touch_en1, int'(touch_addr1), int'(touch_way1));
      end
      @(posedge clk);
      #1;
      check_eq("busy_a", busy_a, m_busy);
      check_eq("tag_a", tag_a, pack_tags(0, 1, 2));
      check_eq("val_a", val_a, e_vm[0][1]);
      check_eq("vic_a", vic_a, e_vic[0][1]);
      check_eq("busy_b", busy_b, m_busy);
      check_eq("tag_b", tag_b, pack_tags(0, 0, 2));
      check_eq("val_b", val_b, e_vm[0][0]);
      check_eq("vic_b", vic_b, e_vic[0][0]);
      check_eq("busy_c", busy_c, m_busy);
      check_eq("tag_c", tag_c, pack_tags(1, 1, 4));
      check_eq("val_c", val_c, e_vm[1][1]);
      check_eq("vic_c", vic_c, e_vic[1][1]);
   endtask

   task automatic idle_inputs();
      rd_en0 = 0; wr_en0 = 0; touch_en0 = 0; wr_valid0 = 0;
      rd_addr0 = '0; wr_addr0 = '0; touch_addr0 = '0; wr_way0 = '0; touch_way0 = '0; wr_tag0 = '0;
      rd_en1 = 0; wr_en1 = 0; touch_en1 = 0; wr_valid1 = 0;
      rd_addr1 = '0; wr_addr1 = '0; touch_addr1 = '0; wr_way1 = '0; touch_way1 = '0; wr_tag1 = '0;
   endtask

   function automatic logic [SAW-1:0] rand_set();
      if ($urandom_range(0, 3) == 0) return SAW'($urandom_range(0, SETS - 1));
      return SAW'($urandom_range(0, 7));
   endfunction

   task automatic rand_inputs();
      rd_en0 = 1'($urandom_range(0, 1)); rd_addr0 = rand_set();
      wr_en0 = 1'($urandom_range(0, 1)); wr_addr0 = rand_set();
      wr_way0 = 1'($urandom_range(0, 1)); wr_tag0 = TW'($urandom());
      wr_valid0 = ($urandom_range(0, 3) != 0);
      touch_en0 = 1'($urandom_range(0, 1)); touch_addr0 = rand_set();
      touch_way0 = 1'($urandom_range(0, 1));
      rd_en1 = 1'($urandom_range(0, 1)); rd_addr1 = rand_set();
      wr_en1 = 1'($urandom_range(0, 1)); wr_addr1 = rand_set();
      wr_way1 = 2'($urandom_range(0, 3)); wr_tag1 = TW'($urandom());
      wr_valid1 = ($urandom_range(0, 3) != 0);
      touch_en1 = 1'($urandom_range(0, 1)); touch_addr1 = rand_set();
      touch_way1 = 2'($urandom_range(0, 3));
   endtask

   task automatic wr0(input int a, input int w, input int t, input bit v);
      wr_en0 = 1; wr_addr0 = SAW'(a); wr_way0 = 1'(w); wr_tag0 = TW'(t); wr_valid0 = v;
      tick();
      wr_en0 = 0;
   endtask

   task automatic rd0(input int a);
      rd_en0 = 1; rd_addr0 = SAW'(a);
      tick();
      rd_en0 = 0;
   endtask

   task automatic wr1(input int a, input int w, input int t);
      wr_en1 = 1; wr_addr1 = SAW'(a); wr_way1 = 2'(w); wr_tag1 = TW'(t); wr_valid1 = 1;
      tick();
      wr_en1 = 0;
   endtask

   task automatic touch1(input int a, input int w);
      touch_en1 = 1; touch_addr1 = SAW'(a); touch_way1 = 2'(w);
      tick();
      touch_en1 = 0;
   endtask

   task automatic rd1(input int a);
      rd_en1 = 1; rd_addr1 = SAW'(a);
      tick();
      rd_en1 = 0;
   endtask

   initial begin
      int n;
      n_cmp = 0;
      n_bad = 0;
      idle_inputs();
      rst = 1;
      repeat (3) tick();
      check_eq("rst_busy", busy_a, 1'b1);
      check_eq("rst_tag", tag_a, 0);

      // first sweep, with a write to set 5 that must be ignored
      rst = 0;
      n = 0;
      while (busy_a && n < 300) begin
         wr_en0 = (n == 10); wr_addr0 = 5; wr_way0 = 1; wr_tag0 = 'h1ABCD; wr_valid0 = 1;
         n++;
         tick();
      end
      idle_inputs();
      check_eq("sweep_len", n, 128);
      rd0(5);
      check_eq("s5_valid", val_a, 2'b00);
      check_eq("s5_tag", tag_a, 0);
      check_eq("s5_victim", vic_a, 0);

      wr0(9, 1, 'h1ABCD, 1);
      rd0(9);
      check_eq("s9_valid", val_a, 2'b10);
      check_eq("s9_tag1", tag_a[2*TW-1:TW], 'h1ABCD);
      check_eq("s9_victim", vic_a, 0);

      // same-cycle write and read of set 7
      wr_en0 = 1; wr_addr0 = 7; wr_way0 = 0; wr_tag0 = 'h42; wr_valid0 = 1;
      rd_en0 = 1; rd_addr0 = 7;
      tick();
      idle_inputs();
      check_eq("byp_tag0", tag_a[TW-1:0], 'h42);
      check_eq("nobyp_tag0", tag_b[TW-1:0], 0);

      // set 2: touch way 0 leaves PLRU pointing at way 1, then write way 1 + touch way 0
      wr0(2, 0, 'h111, 1);
      wr0(2, 1, 'h222, 1);
      touch_en0 = 1; touch_addr0 = 2; touch_way0 = 0;
      tick();
      wr_en0 = 1; wr_addr0 = 2; wr_way0 = 1; wr_tag0 = 'h333; wr_valid0 = 1;
      tick();
      idle_inputs();
      rd0(2);
      check_eq("wr_beats_touch", vic_a, 0);

      // 4-way tree PLRU on set 3
      for (int w = 0; w < 4; w++) wr1(3, w, 'h100 + w);
      for (int w = 0; w < 4; w++) touch1(3, w);
      rd1(3);
      check_eq("plru4_v0", vic_c, 0);
      check_eq("plru4_valid", val_c, 4'hF);
      touch1(3, 0);
      rd1(3);
      check_eq("plru4_v2", vic_c, 2);

      repeat (800) begin
         rand_inputs();
         tick();
      end
      idle_inputs();

      // reset pulse in the middle of a sweep
      wr0(9, 1, 'h1ABCD, 1);
      rst = 1;
      tick();
      rst = 0;
      repeat (60) begin
         rand_inputs();
         tick();
      end
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      check_eq("rst2_busy", busy_a, 1'b1);
      n = 0;
      while (busy_a && n < 300) begin
         rand_inputs();
         n++;
         tick();
      end
      idle_inputs();
      check_eq("sweep_len2", n, 128);
      rd0(9);
      check_eq("s9_cleared_valid", val_a, 2'b00);
      check_eq("s9_cleared_tag", tag_a, 0);
      rd1(3);
      check_eq("s3_cleared_valid", val_c, 4'h0);
      check_eq("s3_cleared_victim", vic_c, 0);

      repeat (300) begin
         rand_inputs();
         tick();
      end
      idle_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
